// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - opcode fields, register indices and datapath mux codes for the decode stage
package cpu_pkg;

  localparam logic       OP_LOAD = 1'b0;
  localparam logic [1:0] OP_MOVE = 2'b10;
  localparam logic [2:0] OP_ALU  = 3'b110;
  localparam logic [3:0] OP_JMP  = 4'b1110;
  localparam logic [3:0] OP_JNZ  = 4'b1111;

  localparam logic [2:0] REG_X0 = 3'd0;
  localparam logic [2:0] REG_X1 = 3'd1;
  localparam logic [2:0] REG_Y0 = 3'd2;
  localparam logic [2:0] REG_Y1 = 3'd3;
  localparam logic [2:0] REG_R  = 3'd4;
  localparam logic [2:0] REG_M  = 3'd5;
  localparam logic [2:0] REG_I  = 3'd6;
  localparam logic [2:0] REG_O  = 3'd7;

  typedef enum logic [1:0] {
    DSEL_IMM  = 2'd0,
    DSEL_MOVE = 2'd1,
    DSEL_ALU  = 2'd2
  } data_sel_e;

  localparam logic [3:0] ALU_FN_NOP = 4'h0;

  function automatic logic [7:0] reg_onehot(input logic [2:0] idx);
    return 8'b0000_0001 << idx;
  endfunction

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - active-low async reset in, active-high reset out, released after SYNC_STAGES edges
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic sync_reset
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Zeros shift in from the bottom once reset_n is high; the top flop drives the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chain <= '1;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign sync_reset = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/instruction_decoder.sv
// rtl/instruction_decoder.sv - decode stage: jump controls, register write strobes, zero flag, reset sync
// Optional performance counters are compiled in with DECODER_PERF_CNT_EN.
module instruction_decoder
  import cpu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  pm_data,
  input  logic        alu_zero,
  output logic        sync_reset,
  output logic        jmp,
  output logic        jmp_nz,
  output logic [3:0]  jmp_addr,
  output logic        dont_jmp,
  output logic [7:0]  reg_en,
  output logic [2:0]  src_sel,
  output logic [1:0]  data_sel,
  output logic [3:0]  imm,
  output logic [7:0]  ir
`ifdef DECODER_PERF_CNT_EN
  ,
  output logic [15:0] instr_cnt,
  output logic [15:0] jmp_taken_cnt
`endif
);

  logic       w_sync_reset;
  logic [7:0] w_reg_en;
  logic [1:0] w_data_sel;
  logic       w_jmp;
  logic       w_jmp_nz;
  logic       w_alu_wr;
  logic       r_z;
  logic [7:0] r_ir;

  reset_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_reset_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .sync_reset (w_sync_reset)
  );

  always_comb begin
    w_reg_en   = 8'h00;
    w_data_sel = DSEL_IMM;
    w_jmp      = 1'b0;
    w_jmp_nz   = 1'b0;
    w_alu_wr   = 1'b0;
    if (pm_data[7] == OP_LOAD) begin
      w_reg_en = reg_onehot(pm_data[6:4]);
    end else if (pm_data[7:6] == OP_MOVE) begin
      w_data_sel = DSEL_MOVE;
      // A move onto itself is the architectural NOP.
      if (pm_data[5:3] != pm_data[2:0]) begin
        w_reg_en = reg_onehot(pm_data[5:3]);
      end
    end else if (pm_data[7:5] == OP_ALU) begin
      w_data_sel = DSEL_ALU;
      w_alu_wr   = (pm_data[3:0] != ALU_FN_NOP);
      if (w_alu_wr) begin
        w_reg_en = reg_onehot(REG_R);
      end
    end else if (pm_data[7:4] == OP_JMP) begin
      w_jmp = 1'b1;
    end else begin
      w_jmp_nz = (pm_data[7:4] == OP_JNZ);
    end
  end

  assign sync_reset = w_sync_reset;
  assign jmp        = w_jmp & ~w_sync_reset;
  assign jmp_nz     = w_jmp_nz & ~w_sync_reset;
  assign reg_en     = w_sync_reset ? 8'h00 : w_reg_en;
  assign jmp_addr   = pm_data[3:0];
  assign imm        = pm_data[3:0];
  assign src_sel    = pm_data[2:0];
  assign data_sel   = w_data_sel;
  assign dont_jmp   = r_z;
  assign ir         = r_ir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_z  <= 1'b0;
      r_ir <= 8'h00;
    end else begin
      r_ir <= pm_data;
      if (!w_sync_reset && w_alu_wr) begin
        r_z <= alu_zero;
      end
    end
  end

`ifdef DECODER_PERF_CNT_EN
  logic [15:0] r_instr_cnt;
  logic [15:0] r_jmp_taken_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_cnt     <= 16'h0000;
      r_jmp_taken_cnt <= 16'h0000;
    end else if (w_sync_reset) begin
      r_instr_cnt     <= 16'h0000;
      r_jmp_taken_cnt <= 16'h0000;
    end else begin
      r_instr_cnt <= r_instr_cnt + 16'd1;
      if (jmp | (jmp_nz & ~r_z)) begin
        r_jmp_taken_cnt <= r_jmp_taken_cnt + 16'd1;
      end
    end
  end

  assign instr_cnt     = r_instr_cnt;
  assign jmp_taken_cnt = r_jmp_taken_cnt;
`endif

endmodule

// File: tb/tb_instruction_decoder.sv
// tb/tb_instruction_decoder.sv - scoreboard bench for instruction_decoder (perf checks with DECODER_PERF_CNT_EN)
module tb_instruction_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  pm_data;
  logic        alu_zero;
  logic        sync_reset;
  logic        jmp;
  logic        jmp_nz;
  logic [3:0]  jmp_addr;
  logic        dont_jmp;
  logic [7:0]  reg_en;
  logic [2:0]  src_sel;
  logic [1:0]  data_sel;
  logic [3:0]  imm;
  logic [7:0]  ir;
`ifdef DECODER_PERF_CNT_EN
  logic [15:0] instr_cnt;
  logic [15:0] jmp_taken_cnt;
`endif

  instruction_decoder #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pm_data       (pm_data),
    .alu_zero      (alu_zero),
    .sync_reset    (sync_reset),
    .jmp           (jmp),
    .jmp_nz        (jmp_nz),
    .jmp_addr      (jmp_addr),
    .dont_jmp      (dont_jmp),
    .reg_en        (reg_en),
    .src_sel       (src_sel),
    .data_sel      (data_sel),
    .imm           (imm),
    .ir            (ir)
`ifdef DECODER_PERF_CNT_EN
    ,
    .instr_cnt     (instr_cnt),
    .jmp_taken_cnt (jmp_taken_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] reg_en;
    logic [2:0] src_sel;
    logic [1:0] data_sel;
    logic [3:0] imm;
    logic [3:0] addr;
    logic       jmp;
    logic       jnz;
    logic       alu_wr;
    logic       chk_dsel;
    logic       chk_src;
  } dec_t;

  int          errors = 0;
  int          checks = 0;
  logic        m_z;
  logic [15:0] m_instr;
  logic [15:0] m_taken;
  dec_t        dec_q[$];
  logic [8:0]  seq_q[$];

  function automatic dec_t model(input logic [7:0] op);
    dec_t d;
    d      = '0;
    d.imm  = op[3:0];
    d.addr = op[3:0];
    casez (op)
      8'b0???????: begin
        d.reg_en[op[6:4]] = 1'b1;
        d.data_sel = 2'd0;
        d.chk_dsel = 1'b1;
      end
      8'b10??????: begin
        d.src_sel  = op[2:0];
        d.data_sel = 2'd1;
        d.chk_dsel = 1'b1;
        d.chk_src  = 1'b1;
        if (op[5:3] != op[2:0]) d.reg_en[op[5:3]] = 1'b1;
      end
      8'b110?????: begin
        d.data_sel = 2'd2;
        d.chk_dsel = 1'b1;
        d.alu_wr   = (op[3:0] != 4'h0);
        if (d.alu_wr) d.reg_en = 8'b0001_0000;
      end
      8'b1110????: d.jmp = 1'b1;
      default:     d.jnz = 1'b1;
    endcase
    return d;
  endfunction

  // One instruction cycle: drive at negedge, check decode 1ns later, check registered state after the edge.
  task automatic step(input logic [7:0] op, input logic az);
    dec_t e;
    dec_t g;
    logic [8:0] s;
    @(negedge clk);
    pm_data  = op;
    alu_zero = az;
    e = model(op);
    dec_q.push_back(e);
    if (e.jmp || (e.jnz && !m_z)) m_taken = m_taken + 16'd1;
    m_instr = m_instr + 16'd1;
    if (e.alu_wr) m_z = az;
    seq_q.push_back({op, m_z});
    #1;
    g = dec_q.pop_front();
    checks++;
    if (reg_en !== g.reg_en) begin
      errors++; $display("FAIL reg_en op=%02h: got %b expected %b", op, reg_en, g.reg_en);
    end
    checks++;
    if (jmp !== g.jmp || jmp_nz !== g.jnz) begin
      errors++; $display("FAIL jmp/jmp_nz op=%02h: got %b/%b expected %b/%b", op, jmp, jmp_nz, g.jmp, g.jnz);
    end
    checks++;
    if (jmp_addr !== g.addr || imm !== g.imm) begin
      errors++; $display("FAIL addr/imm op=%02h: got %h/%h expected %h/%h", op, jmp_addr, imm, g.addr, g.imm);
    end
    if (g.chk_dsel) begin
      checks++;
      if (data_sel !== g.data_sel) begin
        errors++; $display("FAIL data_sel op=%02h: got %0d expected %0d", op, data_sel, g.data_sel);
      end
    end
    if (g.chk_src) begin
      checks++;
      if (src_sel !== g.src_sel) begin
        errors++; $display("FAIL src_sel op=%02h: got %0d expected %0d", op, src_sel, g.src_sel);
      end
    end
    checks++;
    if (jmp === 1'b1 && jmp_nz === 1'b1) begin
      errors++; $display("FAIL jmp_exclusive op=%02h: got both 1 expected at most one", op);
    end
    @(posedge clk);
    #1;
    s = seq_q.pop_front();
    checks++;
    if (ir !== s[8:1]) begin
      errors++; $display("FAIL ir op=%02h: got %02h expected %02h", op, ir, s[8:1]);
    end
    checks++;
    if (dont_jmp !== s[0]) begin
      errors++; $display("FAIL dont_jmp op=%02h az=%b: got %b expected %b", op, az, dont_jmp, s[0]);
    end
`ifdef DECODER_PERF_CNT_EN
    checks++;
    if (instr_cnt !== m_instr || jmp_taken_cnt !== m_taken) begin
      errors++; $display("FAIL perf_cnt op=%02h: got %h/%h expected %h/%h", op, instr_cnt, jmp_taken_cnt, m_instr, m_taken);
    end
`endif
  endtask

  task automatic reset_model();
    m_z     = 1'b0;
    m_instr = 16'h0000;
    m_taken = 16'h0000;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    pm_data  = 8'h35;
    alu_zero = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (sync_reset !== 1'b1 || dont_jmp !== 1'b0 || ir !== 8'h00 || reg_en !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got srst=%b dj=%b ir=%02h en=%02h expected 1/0/00/00", i, sync_reset, dont_jmp, ir, reg_en);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    pm_data = 8'hE7;
    @(posedge clk);
    #1;
    checks++;
    if (sync_reset !== 1'b1 || jmp !== 1'b0) begin
      errors++; $display("FAIL release_edge1: got srst=%b jmp=%b expected 1/0", sync_reset, jmp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sync_reset !== 1'b0) begin
      errors++; $display("FAIL release_edge2: got srst=%b expected 0", sync_reset);
    end
`ifdef DECODER_PERF_CNT_EN
    checks++;
    if (instr_cnt !== 16'h0000 || jmp_taken_cnt !== 16'h0000) begin
      errors++; $display("FAIL perf_reset: got %h/%h expected 0000/0000", instr_cnt, jmp_taken_cnt);
    end
`endif
    reset_model();
  endtask

  task automatic test_load_move();
    step(8'h35, 1'b0);
    step(8'h8A, 1'b0);
    step(8'h89, 1'b0);
    step(8'h7F, 1'b0);
    step(8'hBE, 1'b0);
  endtask

  task automatic test_zero_flag();
    step(8'hC1, 1'b1);
    step(8'hF3, 1'b0);
    step(8'hC1, 1'b0);
    step(8'hF3, 1'b1);
    step(8'hC0, 1'b1);
    step(8'hC8, 1'b1);
    step(8'hD0, 1'b0);
    step(8'hE5, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      step({3'b110, 1'(i), 4'(i + 1)}, 1'(i));
      step({4'hF, 4'(i)}, 1'b0);
    end
  endtask

  task automatic test_decode_sweep();
    for (int i = 0; i < 48; i++) begin
      step(8'($urandom), 1'($urandom));
    end
  endtask

  task automatic test_mid_reset();
    step(8'hC1, 1'b1);
    @(negedge clk);
    pm_data = 8'hE7;
    #1;
    checks++;
    if (jmp !== 1'b1) begin
      errors++; $display("FAIL mid_pre_jmp: got %b expected 1", jmp);
    end
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (jmp !== 1'b0 || sync_reset !== 1'b1 || ir !== 8'h00 || dont_jmp !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got jmp=%b srst=%b ir=%02h dj=%b expected 0/1/00/0", jmp, sync_reset, ir, dont_jmp);
    end
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (sync_reset !== 1'b1) begin
      errors++; $display("FAIL short_pulse_edge1: got %b expected 1", sync_reset);
    end
    @(posedge clk);
    #1;
    checks++;
    if (sync_reset !== 1'b0) begin
      errors++; $display("FAIL short_pulse_edge2: got %b expected 0", sync_reset);
    end
    reset_model();
    step(8'hE2, 1'b0);
  endtask

  task automatic test_counter_wrap();
`ifdef DECODER_PERF_CNT_EN
    force dut.r_instr_cnt = 16'hFFFF;
    #1;
    release dut.r_instr_cnt;
    m_instr = 16'hFFFF;
    step(8'h12, 1'b0);
    checks++;
    if (instr_cnt !== 16'h0000) begin
      errors++; $display("FAIL instr_cnt_wrap: got %h expected 0000", instr_cnt);
    end
`endif
    step(8'h20, 1'b0);
  endtask

  initial begin
    reset_model();
    test_reset();
    test_load_move();
    test_zero_flag();
    test_back_to_back();
    test_decode_sweep();
    test_mid_reset();
    test_counter_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
